// File: rtl/pcie_tx_skp_inserter.sv
// pcie_tx_skp_inserter: merges periodic SKP ordered sets into a 32-bit TX word stream
// ahead of the scrambler. SKP insertion is deferred while a packet is open (between an
// STP/SDP and its END/EDB), and up to three requests are queued.
// Optional statistics ports are enabled by defining PCIE_TX_SKP_STATS_EN.
module pcie_tx_skp_inserter #(
  parameter int unsigned SKP_INTERVAL = 295
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  datak_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [31:0] data_o,
  output logic [3:0]  datak_o,
  output logic [1:0]  data_len_o
`ifdef PCIE_TX_SKP_STATS_EN
  ,
  output logic [15:0] skp_cnt_o,
  output logic        skp_drop_o
`endif
);

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned PEND_W   = 2;
  localparam int unsigned NUM_SYM  = 4;
  localparam logic [CNT_W-1:0]  CNT_WRAP = CNT_W'(SKP_INTERVAL - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(3);
  localparam logic [31:0] SKP_WORD  = 32'h1C1C1CBC;
  localparam logic [3:0]  SKP_K     = 4'b1111;
  localparam logic [7:0]  SYM_STP   = 8'hFB;
  localparam logic [7:0]  SYM_SDP   = 8'h5C;
  localparam logic [7:0]  SYM_END   = 8'hFD;
  localparam logic [7:0]  SYM_EDB   = 8'hFE;

  logic [CNT_W-1:0]  interval_cnt_q;
  logic [PEND_W-1:0] pend_q;
  logic [PEND_W-1:0] pend_d;
  logic              in_pkt_q;
  logic              in_pkt_d;
  logic              skp_req;
  logic              insert;
  logic              accept;
  logic              drop;
  logic [7:0]        sym;

  assign data_len_o = 2'b10;

  // Insert/accept decode; ready derives only from registered state
  always_comb begin
    skp_req = (interval_cnt_q == CNT_WRAP);
    insert  = (pend_q != '0) && !in_pkt_q;
    ready_o = !insert;
    accept  = valid_i && ready_o;
    drop    = skp_req && !insert && (pend_q == PEND_MAX);
  end

  // Pending-request counter: +1 per request (saturating), -1 per insert
  always_comb begin
    pend_d = pend_q;
    unique case ({skp_req, insert})
      2'b10:   pend_d = (pend_q == PEND_MAX) ? PEND_MAX : pend_q + PEND_W'(1);
      2'b01:   pend_d = pend_q - PEND_W'(1);
      default: pend_d = pend_q;
    endcase
  end

  // Packet tracking: scan symbols in order so the last framing symbol wins
  always_comb begin
    in_pkt_d = in_pkt_q;
    sym      = '0;
    if (accept) begin
      for (int b = 0; b < int'(NUM_SYM); b++) begin
        sym = data_i[8*b +: 8];
        if (datak_i[b]) begin
          if ((sym == SYM_STP) || (sym == SYM_SDP)) begin
            in_pkt_d = 1'b1;
          end else if ((sym == SYM_END) || (sym == SYM_EDB)) begin
            in_pkt_d = 1'b0;
          end
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      interval_cnt_q <= '0;
      pend_q         <= '0;
      in_pkt_q       <= 1'b0;
      data_o         <= '0;
      datak_o        <= '0;
    end else begin
      interval_cnt_q <= skp_req ? '0 : interval_cnt_q + CNT_W'(1);
      pend_q         <= pend_d;
      in_pkt_q       <= in_pkt_d;
      if (insert) begin
        data_o  <= SKP_WORD;
        datak_o <= SKP_K;
      end else if (accept) begin
        data_o  <= data_i;
        datak_o <= datak_i;
      end else begin
        data_o  <= '0;
        datak_o <= '0;
      end
    end
  end

`ifdef PCIE_TX_SKP_STATS_EN
  // Emitted-SKP counter and dropped-request pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      skp_cnt_o  <= '0;
      skp_drop_o <= 1'b0;
    end else begin
      if (insert) begin
        skp_cnt_o <= skp_cnt_o + 16'(1);
      end
      skp_drop_o <= drop;
    end
  end
`endif

endmodule
